// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS fetch front end.
//   if_state_e       : fetch FSM states (request, skid-buffered, drop-in-flight)
//   INSTR_NOP        : all-zero instruction word placed in IF/ID for bubbles
//   RESET_PC_DEFAULT : default PC loaded on reset
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_BUF  = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Holds its contents unless told to load or clear.
// Clear wins over load and leaves a bubble (valid=0, instr=NOP); the PC+4
// copy is left untouched on a clear because nothing downstream reads it
// without valid.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   load_en          : write {pc_plus_4_in, instr_in} as a live instruction
//   clear_en         : write a bubble (takes priority over load_en)
//   pc_plus_4_in     : PC+4 of the instruction being loaded
//   instr_in         : instruction word being loaded
//   id_pc_plus_4     : registered PC+4
//   id_instr         : registered instruction
//   id_valid         : registered valid flag
// ---------------------------------------------------------------------------
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        clear_en,
  input  logic [31:0] pc_plus_4_in,
  input  logic [31:0] instr_in,
  output logic [31:0] id_pc_plus_4,
  output logic [31:0] id_instr,
  output logic        id_valid
);

  logic [31:0] id_pc_plus_4_q, id_pc_plus_4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;

  always_comb begin
    id_pc_plus_4_d = id_pc_plus_4_q;
    id_instr_d     = id_instr_q;
    id_valid_d     = id_valid_q;
    if (clear_en) begin
      id_instr_d = INSTR_NOP;
      id_valid_d = 1'b0;
    end else if (load_en) begin
      id_pc_plus_4_d = pc_plus_4_in;
      id_instr_d     = instr_in;
      id_valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_plus_4_q <= 32'h0;
      id_instr_q     <= INSTR_NOP;
      id_valid_q     <= 1'b0;
    end else begin
      id_pc_plus_4_q <= id_pc_plus_4_d;
      id_instr_q     <= id_instr_d;
      id_valid_q     <= id_valid_d;
    end
  end

  assign id_pc_plus_4 = id_pc_plus_4_q;
  assign id_instr     = id_instr_q;
  assign id_valid     = id_valid_q;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction fetch stage: PC register, fetch FSM, one-entry skid buffer and
// the IF/ID register (if_id_reg).
//   IF_REQ  : request at PC; accept data into IF/ID, or into the skid buffer
//             if ID is stalled.
//   IF_BUF  : skid buffer full, no request; drains into IF/ID when stall drops.
//   IF_DROP : a flush arrived while a read was outstanding; keep the address
//             stable until the memory answers, throw the data away, then
//             resume at the saved redirect target.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   pc_next        : next PC from the next-PC select logic
//   stall          : ID cannot accept (hold IF/ID)
//   flush          : taken branch/jump; kill fetch, redirect to pc_next
//   imem_req/addr  : instruction memory request and address (= PC)
//   imem_ready     : read data valid this cycle
//   imem_rdata     : instruction word
//   pc_plus_4      : PC + 4
//   id_pc_plus_4, id_instr, id_valid : IF/ID register outputs
//   fetch_wait     : request outstanding and memory not ready
// Optional (macro IF_PERF_CNT_EN):
//   perf_fetch_cnt : instructions written valid into IF/ID (wraps)
//   perf_wait_cnt  : cycles with fetch_wait high (wraps)
// ---------------------------------------------------------------------------
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus_4,
  output logic [31:0] id_pc_plus_4,
  output logic [31:0] id_instr,
  output logic        id_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt,
`endif
  output logic        fetch_wait
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] redirect_q, redirect_d;

  logic        load_en;
  logic        clear_en;
  logic [31:0] load_pc4;
  logic [31:0] load_instr;

  // Address comes straight from the PC register, so it cannot move while a
  // read is outstanding: the PC only changes on ready, flush from BUF, or in
  // BUF where no request is issued.
  assign imem_req   = (state_q != IF_BUF);
  assign imem_addr  = pc_q;
  assign pc_plus_4  = pc_q + 32'd4;
  assign fetch_wait = imem_req & ~imem_ready;

  // Next-state logic. Flush is tested first in every state so it always
  // beats stall.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_pc4_d   = buf_pc4_q;
    buf_instr_d = buf_instr_q;
    redirect_d  = redirect_q;
    load_en     = 1'b0;
    clear_en    = 1'b0;
    load_pc4    = pc_plus_4;
    load_instr  = imem_rdata;

    case (state_q)
      IF_REQ: begin
        if (flush) begin
          clear_en = 1'b1;
          if (imem_ready) begin
            pc_d = pc_next;
          end else begin
            redirect_d = pc_next;
            state_d    = IF_DROP;
          end
        end else if (imem_ready) begin
          pc_d = pc_next;
          if (stall) begin
            buf_pc4_d   = pc_plus_4;
            buf_instr_d = imem_rdata;
            state_d     = IF_BUF;
          end else begin
            load_en = 1'b1;
          end
        end else if (!stall) begin
          clear_en = 1'b1;
        end
      end

      IF_BUF: begin
        if (flush) begin
          clear_en = 1'b1;
          pc_d     = pc_next;
          state_d  = IF_REQ;
        end else if (!stall) begin
          load_en    = 1'b1;
          load_pc4   = buf_pc4_q;
          load_instr = buf_instr_q;
          state_d    = IF_REQ;
        end
      end

      IF_DROP: begin
        // A repeated flush replaces the target; the latest one wins even in
        // the cycle the abandoned read completes.
        if (flush) begin
          clear_en   = 1'b1;
          redirect_d = pc_next;
        end
        if (imem_ready) begin
          pc_d    = flush ? pc_next : redirect_q;
          state_d = IF_REQ;
        end
      end

      default: begin
        state_d = IF_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IF_REQ;
      pc_q        <= RESET_PC;
      buf_pc4_q   <= 32'h0;
      buf_instr_q <= INSTR_NOP;
      redirect_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_pc4_q   <= buf_pc4_d;
      buf_instr_q <= buf_instr_d;
      redirect_q  <= redirect_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .clear_en     (clear_en),
    .pc_plus_4_in (load_pc4),
    .instr_in     (load_instr),
    .id_pc_plus_4 (id_pc_plus_4),
    .id_instr     (id_instr),
    .id_valid     (id_valid)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'b0, (load_en & ~clear_en)};
    wait_cnt_d  = wait_cnt_q + {31'b0, fetch_wait};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      wait_cnt_q  <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Randomized bench for if_stage against a transaction-level reference model
// (current PC, a queue holding at most one parked instruction, and a pending
// redirect). Also covers an asynchronous reset in the middle of a wait.
// Perf counter ports are connected and checked when IF_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_next;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_plus_4;
  logic [31:0] id_pc_plus_4;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        fetch_wait;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;
`endif

  int checkCount = 0;
  int passCount  = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_next      (pc_next),
    .stall        (stall),
    .flush        (flush),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .pc_plus_4    (pc_plus_4),
    .id_pc_plus_4 (id_pc_plus_4),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt),
`endif
    .fetch_wait   (fetch_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: fetch stream seen as transactions, not FSM states.
  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } entry_t;

  logic [31:0] mPc;
  entry_t      mParked[$];
  logic        mDropping;
  logic [31:0] mRedirect;
  logic        mIdValid;
  logic [31:0] mIdInstr;
  logic [31:0] mIdPc4;
  logic [31:0] mFetchCnt;
  logic [31:0] mWaitCnt;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
  endtask

  task automatic modelReset();
    mPc       = 32'h0;
    mParked.delete();
    mDropping = 1'b0;
    mRedirect = 32'h0;
    mIdValid  = 1'b0;
    mIdInstr  = 32'h0;
    mIdPc4    = 32'h0;
    mFetchCnt = 32'h0;
    mWaitCnt  = 32'h0;
  endtask

  // Advance the model by one clock for the given inputs.
  task automatic modelStep(input logic st, input logic fl, input logic rdy,
                           input logic [31:0] pcn);
    entry_t e;
    if (mParked.size() == 0 && !rdy) mWaitCnt++;
    if (mParked.size() != 0) begin
      if (fl) begin
        mParked.delete();
        mIdValid = 1'b0;
        mIdInstr = 32'h0;
        mPc      = pcn;
      end else if (!st) begin
        e = mParked.pop_front();
        mIdValid = 1'b1;
        mIdInstr = e.instr;
        mIdPc4   = e.pc4;
        mFetchCnt++;
      end
    end else if (mDropping) begin
      if (fl) begin
        mRedirect = pcn;
        mIdValid  = 1'b0;
        mIdInstr  = 32'h0;
      end
      if (rdy) begin
        mPc       = mRedirect;
        mDropping = 1'b0;
      end
    end else if (fl) begin
      mIdValid = 1'b0;
      mIdInstr = 32'h0;
      if (rdy) mPc = pcn;
      else begin
        mRedirect = pcn;
        mDropping = 1'b1;
      end
    end else if (rdy) begin
      e.pc4   = mPc + 32'd4;
      e.instr = memWord(mPc);
      if (st) mParked.push_back(e);
      else begin
        mIdValid = 1'b1;
        mIdInstr = e.instr;
        mIdPc4   = e.pc4;
        mFetchCnt++;
      end
      mPc = pcn;
    end else if (!st) begin
      mIdValid = 1'b0;
      mIdInstr = 32'h0;
    end
  endtask

  task automatic checkRegistered();
    checkOutput("id_valid", {31'b0, id_valid}, {31'b0, mIdValid});
    checkOutput("id_instr", id_instr, mIdInstr);
    if (mIdValid) checkOutput("id_pc_plus_4", id_pc_plus_4, mIdPc4);
    checkOutput("imem_addr", imem_addr, mPc);
    checkOutput("pc_plus_4", pc_plus_4, mPc + 32'd4);
`ifdef IF_PERF_CNT_EN
    checkOutput("perf_fetch_cnt", perf_fetch_cnt, mFetchCnt);
    checkOutput("perf_wait_cnt", perf_wait_cnt, mWaitCnt);
`endif
  endtask

  // One cycle: check state, drive inputs at the falling edge, check the
  // combinational outputs, then step the model for the coming rising edge.
  task automatic applyStimulus(input logic st, input logic fl, input logic rdy,
                               input logic [31:0] pcn);
    @(negedge clk);
    checkRegistered();
    stall      = st;
    flush      = fl;
    imem_ready = rdy;
    pc_next    = pcn;
    imem_rdata = rdy ? memWord(mPc) : $urandom;
    #1;
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, (mParked.size() == 0)});
    checkOutput("fetch_wait", {31'b0, fetch_wait},
                {31'b0, (mParked.size() == 0) && !rdy});
    modelStep(st, fl, rdy, pcn);
  endtask

  function automatic logic [31:0] pickNext();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom & 32'hFFFF_FFFC;
    if (r == 1) return 32'hFFFF_FFF8;
    return mPc + 32'd4;
  endfunction

  task automatic randomCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) < 7), pickNext());
    end
  endtask

  initial begin
    rst        = 1'b1;
    stall      = 1'b0;
    flush      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    pc_next    = 32'h0;
    modelReset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_id_pc_plus_4", id_pc_plus_4, 32'h0);

    // Zero-wait straight-line fetch from reset.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, mPc + 32'd4);
    // A three-cycle memory wait.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, mPc + 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, mPc + 32'd4);
    // Park a word behind a two-cycle stall, then drain it.
    applyStimulus(1'b1, 1'b0, 1'b1, mPc + 32'd4);
    applyStimulus(1'b1, 1'b0, 1'b1, mPc + 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, mPc + 32'd4);
    // Flush while a read is outstanding, then the abandoned read returns.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0400);
    applyStimulus(1'b0, 1'b0, 1'b0, mPc + 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, mPc + 32'd4);
    // Flush together with stall while a word is parked.
    applyStimulus(1'b1, 1'b0, 1'b1, mPc + 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0800);

    randomCycles(800);

    // Asynchronous reset in the middle of a memory wait.
    applyStimulus(1'b0, 1'b0, 1'b0, mPc + 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, mPc + 32'd4);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_rst_id_valid", {31'b0, id_valid}, 32'h0);
    checkOutput("async_rst_id_instr", id_instr, 32'h0);
    checkOutput("async_rst_id_pc_plus_4", id_pc_plus_4, 32'h0);
    checkOutput("async_rst_imem_addr", imem_addr, 32'h0);
    checkOutput("async_rst_imem_req", {31'b0, imem_req}, 32'h1);
`ifdef IF_PERF_CNT_EN
    checkOutput("async_rst_fetch_cnt", perf_fetch_cnt, 32'h0);
    checkOutput("async_rst_wait_cnt", perf_wait_cnt, 32'h0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b1, mPc + 32'd4);
    randomCycles(400);
    @(negedge clk);
    checkRegistered();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: pc_next  in  32  next PC from next-PC select logic.
REQ-005 SHALL have port: stall  in  1  ID stage cannot accept; hold IF/ID.
REQ-006 SHALL have port: flush  in  1  branch/jump/jr taken; kill fetched instruction, redirect to pc_next.
REQ-007 SHALL have port: imem_req  out  1  instruction-memory read request.
REQ-008 SHALL have port: imem_addr  out  32  fetch address, equal to current PC.
REQ-009 SHALL have port: imem_ready  in  1  read data valid this cycle.
REQ-010 SHALL have port: imem_rdata  in  32  instruction word.
REQ-011 SHALL have port: pc_plus_4  out  32  current PC + 4, to next-PC select.
REQ-012 SHALL have port: id_pc_plus_4  out  32  IF/ID copy of PC + 4 (used by EX for branch/jump targets).
REQ-013 SHALL have port: id_instr  out  32  IF/ID instruction.
REQ-014 SHALL have port: id_valid  out  1  IF/ID holds a live instruction.
REQ-015 SHALL have port: fetch_wait  out  1  high when imem_req=1 and imem_ready=0.

Function
REQ-016 SHALL implement FSM states REQ, BUF, DROP; pc_plus_4 = PC+4 modulo 2^32.
REQ-017 SHALL hold imem_addr stable while imem_req=1 and imem_ready=0; imem_req=1 in REQ and DROP, 0 in BUF.
REQ-018 REQ, ready=1, flush=0, stall=0: IF/ID <= {PC+4, rdata, valid=1}; PC <= pc_next; stay REQ (one instruction per cycle with zero-wait memory).
REQ-019 REQ, ready=1, flush=0, stall=1: rdata and PC+4 into skid buffer; PC <= pc_next; IF/ID unchanged; go BUF.
REQ-020 REQ, ready=0, flush=0: stall=0 -> id_valid <= 0, id_instr <= 0 (bubble); stall=1 -> IF/ID unchanged; PC unchanged.
REQ-021 REQ, flush=1, ready=1: data discarded; id_valid <= 0; PC <= pc_next; stay REQ.
REQ-022 REQ, flush=1, ready=0: redirect register <= pc_next; id_valid <= 0; go DROP.
REQ-023 BUF, flush=0: stall=0 -> IF/ID <= buffer, valid=1, go REQ; stall=1 -> hold.
REQ-024 BUF, flush=1: buffer discarded; id_valid <= 0; PC <= pc_next; go REQ.
REQ-025 DROP: PC held; ready=1 -> data discarded, PC <= redirect register, go REQ; flush=1 again -> redirect <= latest pc_next (last wins, same cycle as ready included).
REQ-026 flush SHALL take priority over stall in every state; flushed IF/ID SHALL read id_valid=0, id_instr=0.

Reset
REQ-027 On rst: PC=RESET_PC, state=REQ, id_valid=0, id_instr=0, id_pc_plus_4=0, buffer and redirect=0, counters=0; takes effect without clk.
REQ-028 Reset mid-request SHALL abandon the outstanding fetch; first post-reset request at RESET_PC.

Configuration
REQ-029 Macro IF_PERF_CNT_EN defined: add outputs perf_fetch_cnt (32, +1 per instruction written into IF/ID with valid=1) and perf_wait_cnt (32, +1 per cycle fetch_wait=1), both wrapping at 2^32; undefined: ports and counters absent, behaviour otherwise identical.

Structure
REQ-030 Shared package mips_pkg SHALL hold the FSM state type, INSTR_NOP (32'h0) and RESET_PC default.
REQ-031 IF/ID register (with stall hold and flush clear) SHALL be sub-module if_id_reg; FSM, PC, skid buffer stay in if_stage.

Verification
REQ-032 Zero-wait memory, no stall/flush, pc_next=pc_plus_4 from reset -> imem_addr 0,4,8,C on consecutive cycles; id_instr follows one cycle later, id_valid=1.
REQ-033 imem_ready low 3 cycles at addr 0x10 -> fetch_wait=1 for 3 cycles, addr held at 0x10, 3 bubbles (id_valid=0), then instruction at 0x10 delivered.
REQ-034 stall=1 for 2 cycles as word from 0x20 returns -> state BUF, IF/ID unchanged, imem_req=0; after stall drops, id_instr = word@0x20, next fetch 0x24.
REQ-035 flush=1, pc_next=0x400 while fetch of 0x30 pending (ready=0) -> DROP; on ready, word@0x30 never reaches ID; next fetch 0x400.
REQ-036 flush=1 and stall=1 same cycle in BUF -> id_valid=0, buffer dropped, next fetch at pc_next.
REQ-037 rst pulsed asynchronously mid-wait -> outputs at reset values immediately; with IF_PERF_CNT_EN, counters read 0.
